// File: rtl/seq_cmp_pkg.sv
// seq_cmp_pkg: FSM state and result encoding shared by the sequential magnitude comparator.
package seq_cmp_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   // Result vector is {eq, lt, gt}
   localparam logic [2:0] RES_EQ = 3'b100;
   localparam logic [2:0] RES_LT = 3'b010;
   localparam logic [2:0] RES_GT = 3'b001;
endpackage

// File: rtl/seq_mag_comparator_cmp_chunk.sv
// cmp_chunk: combinational unsigned compare of one CHUNK-bit slice.
module cmp_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   output logic             lt,
   output logic             gt
);
   assign lt = x < y;
   assign gt = x > y;
endmodule

// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: MSB-first chunk-serial magnitude compare with early exit.
// Define SEQ_CMP_SIGNED_EN to add the signed_mode port (two's-complement compare).
module seq_mag_comparator
   import seq_cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SEQ_CMP_SIGNED_EN
   input  logic             signed_mode,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             lt,
   output logic             gt,
   output logic             busy
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   state_t           state;
   logic [WIDTH-1:0] sa, sb, cap_a, cap_b;
   logic [CW-1:0]    cnt;
   logic [2:0]       res;
   logic             c_lt, c_gt;
`ifdef SEQ_CMP_SIGNED_EN
   // Flipping the sign bit maps two's complement onto offset binary, so RUN stays unsigned
   assign cap_a = a ^ (WIDTH'(signed_mode) << (WIDTH - 1));
   assign cap_b = b ^ (WIDTH'(signed_mode) << (WIDTH - 1));
`else
   assign cap_a = a;
   assign cap_b = b;
`endif
   cmp_chunk #(.CHUNK(CHUNK)) u_cmp (
      .x (sa[WIDTH-1 -: CHUNK]),
      .y (sb[WIDTH-1 -: CHUNK]),
      .lt(c_lt),
      .gt(c_gt)
   );
   assign in_ready     = state == IDLE;
   assign out_valid    = state == DONE;
   assign busy         = state != IDLE;
   assign {eq, lt, gt} = res;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         cnt   <= '0;
         res   <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               sa    <= cap_a;
               sb    <= cap_b;
               cnt   <= CW'(N - 1);
               state <= RUN;
            end
            RUN: if (c_lt || c_gt) begin
               res   <= c_lt ? RES_LT : RES_GT;
               state <= DONE;
            end else if (cnt == '0) begin
               res   <= RES_EQ;
               state <= DONE;
            end else begin
               sa  <= sa << CHUNK;
               sb  <= sb << CHUNK;
               cnt <= cnt - 1'b1;
            end
            DONE: if (out_ready) begin
               res   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
